mem_wr_slave_ram: RTL and testbench
===================================

// Module: mem_wr_slave_ram
// PURPOSE
//  Slave end of the type_i_mem_wr write bus. Absorbs master writes into a 256-entry register array.
//  Adds a read-back channel: valid/ready request, registered response held under backpressure.
//  Sits behind any type_i_mem_wr master; the test harness uses the read-back channel to check write traffic.
// PARAMETERS
//  WIDTH       16   data width; must match the master's type_i_mem_wr WIDTH
//  INIT_VALUE  0    value loaded into every array entry on reset (WIDTH bits)
// PORTS
//  clk            in   1      single clock, all logic on rising edge
//  reset          in   1      asynchronous, active-high reset
//  wr_addr        in   8      type_i_mem_wr slave addr
//  wr_write       in   1      type_i_mem_wr slave write strobe; one write per cycle while high
//  wr_data        in   WIDTH  type_i_mem_wr slave data
//  rd_req_valid   in   1      read request present
//  rd_req_ready   out  1      request accepted this cycle when valid & ready
//  rd_req_addr    in   8      read address
//  rd_rsp_valid   out  1      response data valid
//  rd_rsp_ready   in   1      consumer takes response when valid & ready
//  rd_rsp_data    out  WIDTH  read data
//  rd_rsp_addr    out  8      address the response belongs to
//  wr_count       out  16     number of writes accepted since reset
//  last_wr_addr   out  8      address of most recent write
// BEHAVIOUR
//  Reset (async, immediate):
//   - all 256 entries = INIT_VALUE
//   - rd_rsp_valid=0, rd_rsp_data=0, rd_rsp_addr=0
//   - wr_count=0, last_wr_addr=0
//   - rd_req_ready is combinational and reads 1 while reset is high.
//   - A reset mid-transfer discards any held response; no partial state survives.
//  Write side:
//   - The slave modport carries no valid; wr_write alone qualifies a write.
//   - On clk edge with wr_write=1: mem[wr_addr]<=wr_data; last_wr_addr<=wr_addr; wr_count<=wr_count+1.
//   - wr_count wraps 0xFFFF->0x0000.
//   - There is no write backpressure: every strobed cycle is taken.
//   - wr_addr and wr_data are ignored while wr_write=0.
//  Read side, two-state response slot:
//   - EMPTY: rd_rsp_valid=0.
//   - FULL: rd_rsp_valid=1; rd_rsp_data and rd_rsp_addr are held stable until the response is taken.
//   - rd_req_ready = !rd_rsp_valid | rd_rsp_ready (pass-through drain).
//   - Accept (valid&ready): on next edge slot=FULL, rd_rsp_data<=mem[rd_req_addr], rd_rsp_addr<=rd_req_addr. Latency 1 cycle.
//   - FULL & rd_rsp_ready & !accept -> EMPTY.
//   - FULL & rd_rsp_ready & accept -> stays FULL with the new data. Back-to-back throughput is 1 read per cycle.
//   - FULL & !rd_rsp_ready: request stalled, slot unchanged. A write to the held address does not alter held data.
//  Read/write collision (same addr, same edge): see CONFIGURATION. Reads of other addresses are unaffected.
// CONFIGURATION
//  Macro: MEM_WR_SLAVE_RAM_BYPASS_EN
//  Defined:
//   - On a collision, rd_rsp_data takes the new wr_data (write-first forwarding).
//   - The array is still updated on the same edge.
//  Undefined:
//   - On a collision, rd_rsp_data takes the pre-write array value (read-first).
//   - The array is updated; the next read of that address returns the new value.
// TESTING
//  1 Reset, then read 0x00 and 0xFF
//    -> rd_rsp_valid 1 cycle after accept, data=INIT_VALUE, wr_count=0, last_wr_addr=0.
//  2 Write 0x1234@0x05, then 0xBEEF@0xFF on consecutive cycles; read both
//    -> 0x1234 and 0xBEEF, wr_count=2, last_wr_addr=0xFF.
//  3 Hold rd_rsp_ready=0 with a response FULL for 5 cycles while writing 0xAAAA to that address
//    -> rd_req_ready=0, rd_rsp_data unchanged.
//    -> Release: one handshake; a subsequent read returns 0xAAAA.
//  4 Streaming reads 0x10..0x17 with rd_rsp_ready=1
//    -> 8 responses on 8 consecutive cycles, in order, rd_rsp_addr matches.
//  5 Collision: mem[0x20]=0x0001; same cycle write 0x0002@0x20 and read 0x20
//    -> 0x0001 without the macro, 0x0002 with it. Both builds run.
//  6 65537 writes
//    -> wr_count=0x0001.
//    Assert reset while a response is FULL -> rd_rsp_valid=0 immediately, array=INIT_VALUE.

Source files
------------

// File: rtl/mem_wr_slave_ram.sv
// mem_wr_slave_ram: type_i_mem_wr slave with a 256-entry register array and a registered read-back channel.
// Optional MEM_WR_SLAVE_RAM_BYPASS_EN forwards same-edge write data to a colliding read (write-first).
module mem_wr_slave_ram #(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       wr_addr,
   input  logic             wr_write,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_req_valid,
   output logic             rd_req_ready,
   input  logic [7:0]       rd_req_addr,
   output logic             rd_rsp_valid,
   input  logic             rd_rsp_ready,
   output logic [WIDTH-1:0] rd_rsp_data,
   output logic [7:0]       rd_rsp_addr,
   output logic [15:0]      wr_count,
   output logic [7:0]       last_wr_addr
);
   typedef enum logic {EMPTY, FULL} slot_t;
   slot_t            state_q, state_d;
   logic [WIDTH-1:0] mem_q [256];
   logic [WIDTH-1:0] rsp_data_q, rd_data_d;
   logic [7:0]       rsp_addr_q, last_wr_addr_q;
   logic [15:0]      wr_count_q;
   logic             accept;
   assign accept = rd_req_valid & rd_req_ready;
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= EMPTY;
      else state_q <= state_d;
   always_comb
      state_d = accept ? FULL : (state_q == FULL && rd_rsp_ready) ? EMPTY : state_q;
   always_comb begin
      rd_rsp_valid = state_q == FULL;
      rd_req_ready = state_q == EMPTY || rd_rsp_ready;
      rd_rsp_data  = rsp_data_q;
      rd_rsp_addr  = rsp_addr_q;
      wr_count     = wr_count_q;
      last_wr_addr = last_wr_addr_q;
   end
`ifdef MEM_WR_SLAVE_RAM_BYPASS_EN
   always_comb
      rd_data_d = (wr_write && wr_addr == rd_req_addr) ? wr_data : mem_q[rd_req_addr];
`else
   always_comb
      rd_data_d = mem_q[rd_req_addr];
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < 256; i++) mem_q[i] <= INIT_VALUE;
         wr_count_q     <= '0;
         last_wr_addr_q <= '0;
      end else if (wr_write) begin
         mem_q[wr_addr] <= wr_data;
         wr_count_q     <= wr_count_q + 16'd1;
         last_wr_addr_q <= wr_addr;
      end
   // Held response only changes on a new accept, so it stays stable under backpressure.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rsp_data_q <= '0;
         rsp_addr_q <= '0;
      end else if (accept) begin
         rsp_data_q <= rd_data_d;
         rsp_addr_q <= rd_req_addr;
      end
endmodule

// File: tb/tb_mem_wr_slave_ram.sv
// tb_mem_wr_slave_ram: scoreboard bench for mem_wr_slave_ram; a reference array predicts every read response.
module tb_mem_wr_slave_ram;
   localparam logic [15:0] INIT = 16'h5A5A;
   logic        clk = 0, reset = 0;
   logic [7:0]  wr_addr = 0, rd_req_addr = 0, rd_rsp_addr, last_wr_addr;
   logic        wr_write = 0, rd_req_valid = 0, rd_req_ready, rd_rsp_valid, rd_rsp_ready = 1;
   logic [15:0] wr_data = 0, rd_rsp_data, wr_count;
   logic [15:0] mem_m [256];
   logic [23:0] sb [$];
   int          errors = 0, checks = 0, takes = 0;

   mem_wr_slave_ram #(.WIDTH(16), .INIT_VALUE(INIT)) dut (
      .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_write(wr_write), .wr_data(wr_data),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
      .rd_rsp_addr(rd_rsp_addr), .wr_count(wr_count), .last_wr_addr(last_wr_addr));

   always #5 clk = ~clk;

   // Reference model: handshakes are sampled mid-cycle, inputs only move just after rising edges.
   always @(negedge clk) if (!reset) begin
      logic [15:0] e;
      logic [23:0] x;
      if (rd_rsp_valid && rd_rsp_ready) begin
         takes++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got addr=%h data=%h, expected no response", rd_rsp_addr, rd_rsp_data);
         end else begin
            x = sb.pop_front();
            if ({rd_rsp_addr, rd_rsp_data} !== x) begin
               errors++;
               $display("FAIL rsp_data: got addr=%h data=%h, expected addr=%h data=%h",
                        rd_rsp_addr, rd_rsp_data, x[23:16], x[15:0]);
            end
         end
      end
      if (rd_req_valid && rd_req_ready) begin
         e = mem_m[rd_req_addr];
`ifdef MEM_WR_SLAVE_RAM_BYPASS_EN
         if (wr_write && wr_addr == rd_req_addr) e = wr_data;
`endif
         sb.push_back({rd_req_addr, e});
      end
      if (wr_write) mem_m[wr_addr] = wr_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mem_m[i] = INIT;
      sb.delete();
   endtask

   task automatic read_req(input logic [7:0] a);
      int n = 0;
      rd_req_valid = 1;
      rd_req_addr  = a;
      @(negedge clk);
      while (!rd_req_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (!rd_req_ready) begin
         errors++;
         $display("FAIL req_accept_timeout: ready=%b after %0d cycles, expected 1", rd_req_ready, n);
      end
      tick();
      rd_req_valid = 0;
   endtask

   task automatic write(input logic [7:0] a, input logic [15:0] d);
      wr_write = 1;
      wr_addr  = a;
      wr_data  = d;
      tick();
      wr_write = 0;
   endtask

   task automatic drain();
      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1;
      model_reset();
      #1;
      checks++;
      if ({rd_rsp_valid, rd_req_ready, wr_count, last_wr_addr, rd_rsp_data, rd_rsp_addr} !== {1'b0, 1'b1, 16'h0, 8'h0, 16'h0, 8'h0}) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b cnt=%h last=%h data=%h addr=%h, expected 0 1 0000 00 0000 00",
                  rd_rsp_valid, rd_req_ready, wr_count, last_wr_addr, rd_rsp_data, rd_rsp_addr);
      end
      repeat (2) tick();
      reset = 0;
      tick();
      foreach (sb[i]) sb.delete();
   endtask

   task automatic test_init_read();
      read_req(8'h00);
      checks++;
      if (rd_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_latency: rsp_valid=%b one cycle after accept, expected 1", rd_rsp_valid);
      end
      read_req(8'hFF);
      drain();
   endtask

   task automatic test_write_read();
      wr_write = 1; wr_addr = 8'h05; wr_data = 16'h1234;
      tick();
      wr_addr = 8'hFF; wr_data = 16'hBEEF;
      tick();
      wr_write = 0;
      checks++;
      if (wr_count !== 16'd2 || last_wr_addr !== 8'hFF) begin
         errors++;
         $display("FAIL write_count: cnt=%h last=%h, expected 0002 ff", wr_count, last_wr_addr);
      end
      read_req(8'h05);
      read_req(8'hFF);
      drain();
   endtask

   task automatic test_backpressure();
      int t0;
      rd_rsp_ready = 0;
      read_req(8'h05);
      rd_req_valid = 1; rd_req_addr = 8'h05;
      wr_write = 1; wr_addr = 8'h05; wr_data = 16'hAAAA;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rd_req_ready !== 1'b0 || rd_rsp_valid !== 1'b1 || rd_rsp_data !== 16'h1234 || rd_rsp_addr !== 8'h05) begin
            errors++;
            $display("FAIL stall_hold: ready=%b valid=%b data=%h addr=%h, expected 0 1 1234 05",
                     rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_addr);
         end
         tick();
      end
      wr_write = 0;
      t0 = takes;
      rd_rsp_ready = 1;
      tick();
      rd_req_valid = 0;
      checks++;
      if (takes != t0 + 1) begin
         errors++;
         $display("FAIL release_handshakes: got %0d, expected 1", takes - t0);
      end
      drain();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 8; i++) write(8'h10 + 8'(i), 16'h0100 * 16'(i) + 16'h0007);
      rd_req_valid = 1; rd_req_addr = 8'h10;
      tick();
      for (int i = 0; i < 8; i++) begin
         if (i < 7) rd_req_addr = 8'h11 + 8'(i);
         else rd_req_valid = 0;
         @(negedge clk);
         checks++;
         if (rd_rsp_valid !== 1'b1 || rd_rsp_addr !== 8'h10 + 8'(i)) begin
            errors++;
            $display("FAIL stream_%0d: valid=%b addr=%h, expected 1 %h", i, rd_rsp_valid, rd_rsp_addr, 8'h10 + 8'(i));
         end
         tick();
      end
      drain();
   endtask

   task automatic test_collision();
      logic [15:0] exp_c;
`ifdef MEM_WR_SLAVE_RAM_BYPASS_EN
      exp_c = 16'h0002;
`else
      exp_c = 16'h0001;
`endif
      write(8'h20, 16'h0001);
      wr_write = 1; wr_addr = 8'h20; wr_data = 16'h0002;
      rd_req_valid = 1; rd_req_addr = 8'h20;
      tick();
      wr_write = 0; rd_req_valid = 0;
      checks++;
      if (rd_rsp_data !== exp_c) begin
         errors++;
         $display("FAIL collision: data=%h, expected %h", rd_rsp_data, exp_c);
      end
      read_req(8'h20);
      drain();
   endtask

   task automatic test_wrap_and_async_reset();
      test_reset();
      for (int i = 0; i < 65537; i++) begin
         wr_write = 1;
         wr_addr  = 8'(i + 3);
         wr_data  = 16'(i) ^ 16'h3C3C;
         tick();
      end
      wr_write = 0;
      checks++;
      if (wr_count !== 16'h0001 || last_wr_addr !== 8'h03) begin
         errors++;
         $display("FAIL wr_count_wrap: cnt=%h last=%h, expected 0001 03", wr_count, last_wr_addr);
      end
      read_req(8'h03);
      read_req(8'h80);
      drain();
      rd_rsp_ready = 0;
      read_req(8'h30);
      #3;
      reset = 1;
      model_reset();
      #1;
      checks++;
      if (rd_rsp_valid !== 1'b0 || rd_rsp_data !== 16'h0 || rd_rsp_addr !== 8'h0 || rd_req_ready !== 1'b1 || wr_count !== 16'h0) begin
         errors++;
         $display("FAIL async_reset: valid=%b data=%h addr=%h ready=%b cnt=%h, expected 0 0000 00 1 0000",
                  rd_rsp_valid, rd_rsp_data, rd_rsp_addr, rd_req_ready, wr_count);
      end
      tick();
      reset = 0;
      rd_rsp_ready = 1;
      tick();
      read_req(8'h30);
      read_req(8'h03);
      drain();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_init_read();
      test_write_read();
      test_backpressure();
      test_stream();
      test_collision();
      test_wrap_and_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
